// File: rtl/seq_isa_pkg.sv
// Instruction-set and FSM definitions shared by the sequence controller
// and the downstream memory module.
package seq_isa_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_END     = 4'h1,
    OP_XOR     = 4'h2,
    OP_ADDI    = 4'h3,
    OP_BGE     = 4'h4,
    OP_JUMP    = 4'h5,
    OP_SMA     = 4'h6,
    OP_NOP_ALT = 4'hF
  } opcode_e;

  // Field positions are counted from the instruction LSB.
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 4;
  localparam int RA_LSB  = 4;
  localparam int IMM_LSB = 8;
  localparam int IMM_W   = 16;
  localparam int RB_LSB  = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_ISSUE
  } state_e;

  // Opcodes 0110..1110 belong to the memory module and are handed off.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= 4'h6) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// Private register file: two combinational read ports, one write port,
// asynchronous active-high reset.
module seq_regfile #(
  parameter int WIDTH = 16,
  parameter int COUNT = 16,
  localparam int AW   = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [AW-1:0]    rd_a_addr_i,
  input  logic [AW-1:0]    rd_b_addr_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_a_data_o,
  output logic [WIDTH-1:0] rd_b_data_o
);

  logic [WIDTH-1:0] regs_q [COUNT];

  // NOTE: this array is built from flops, not a RAM macro, so it can take
  // the asynchronous reset; a true SRAM could not be cleared this way.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < COUNT; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_a_data_o = regs_q[rd_a_addr_i];
  assign rd_b_data_o = regs_q[rd_b_addr_i];

endmodule

// File: rtl/seq_controller.sv
// Sequence controller: fetches instructions from an external RAM, executes
// local ALU/branch opcodes and hands memory opcodes off over valid/ready.
module seq_controller
  import seq_isa_pkg::*;
#(
  parameter int PRIVATE_REG_WIDTH = 16,
  parameter int PRIVATE_REG_COUNT = 16,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int INSTRUCTION_COUNT = 512,
  parameter int IMEM_LATENCY      = 2,
  localparam int IDX_W = $clog2(INSTRUCTION_COUNT),
  localparam int RA_W  = (PRIVATE_REG_COUNT > 1) ? $clog2(PRIVATE_REG_COUNT) : 1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  output logic [IDX_W-1:0]             imem_addr_out,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic                         instr_valid_out,
  input  logic                         instr_ready_in,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         fault_out
);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic [2:0]                   lat_q, lat_d;
  logic                         cmp_q, cmp_d;
  logic                         done_q, done_d;
  logic                         fault_q, fault_d;

  logic [OPC_W-1:0]             opcode;
  logic [RA_W-1:0]              ra, rb;
  logic [IMM_W-1:0]             imm;
  logic [PRIVATE_REG_WIDTH-1:0] ra_data, rb_data, wr_data;
  logic                         we;

  // Register indices take only the low bits, i.e. modulo the register count.
  assign opcode = instr_q[OPC_LSB +: OPC_W];
  assign ra     = instr_q[RA_LSB +: RA_W];
  assign rb     = instr_q[RB_LSB +: RA_W];
  assign imm    = instr_q[IMM_LSB +: IMM_W];

  seq_regfile #(
    .WIDTH (PRIVATE_REG_WIDTH),
    .COUNT (PRIVATE_REG_COUNT)
  ) u_regfile (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rd_a_addr_i (ra),
    .rd_b_addr_i (rb),
    .we_i        (we),
    .wr_addr_i   (ra),
    .wr_data_i   (wr_data),
    .rd_a_data_o (ra_data),
    .rd_b_data_o (rb_data)
  );

  // Advancing past the last program slot finishes the run like END.
  logic             at_last;
  state_e           adv_state;
  logic [IDX_W-1:0] adv_pc;

  assign at_last   = (pc_q == IDX_W'(INSTRUCTION_COUNT - 1));
  assign adv_state = at_last ? ST_IDLE : ST_FETCH;
  assign adv_pc    = at_last ? '0 : pc_q + 1'b1;

  // NOTE: every signal gets a default before the case so that no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    lat_d   = '0;
    cmp_d   = cmp_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    we      = 1'b0;
    wr_data = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          fault_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (lat_q == 3'(IMEM_LATENCY)) begin
          instr_d = imem_data_in;
          state_d = ST_EXEC;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      ST_EXEC: begin
        state_d = adv_state;
        pc_d    = adv_pc;
        done_d  = at_last;
        case (opcode)
          OP_END: begin
            state_d = ST_IDLE;
            pc_d    = '0;
            done_d  = 1'b1;
          end
          OP_XOR: begin
            we      = 1'b1;
            wr_data = ra_data ^ rb_data;
          end
          OP_ADDI: begin
            we      = 1'b1;
            wr_data = rb_data + PRIVATE_REG_WIDTH'(imm);
          end
          OP_BGE: cmp_d = (ra_data >= rb_data);
          OP_JUMP: begin
            if (cmp_q) begin
              done_d = 1'b0;
              if ({16'h0, imm} >= 32'(INSTRUCTION_COUNT)) begin
                state_d = ST_IDLE;
                pc_d    = '0;
                fault_d = 1'b1;
              end else begin
                state_d = ST_FETCH;
                pc_d    = IDX_W'(imm);
              end
            end
          end
          default: begin
            if (is_mem_op(opcode)) begin
              state_d = ST_ISSUE;
              pc_d    = pc_q;
              done_d  = 1'b0;
            end
          end
        endcase
      end

      ST_ISSUE: begin
        if (instr_ready_in) begin
          state_d = adv_state;
          pc_d    = adv_pc;
          done_d  = at_last;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      lat_q   <= '0;
      cmp_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      lat_q   <= lat_d;
      cmp_q   <= cmp_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr_out   = pc_q;
  assign instr_out       = instr_q;
  assign instr_valid_out = (state_q == ST_ISSUE);
  assign busy_out        = (state_q != ST_IDLE);
  assign done_out        = done_q;
  assign fault_out       = fault_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller with a pipelined instruction-RAM model
// (2-cycle latency) and hand-computed expectations per scenario.
module tb_seq_controller;
  import seq_isa_pkg::*;

  localparam int IC = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        valid, busy, done, fault;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  logic [31:0] mem  [IC];
  logic [31:0] pipe [2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= mem[imem_addr];
    pipe[1] <= pipe[0];
  end
  assign imem_data = pipe[1];

  always @(negedge clk) if (valid && ready) hs_cnt++;

  seq_controller #(
    .PRIVATE_REG_WIDTH (16),
    .PRIVATE_REG_COUNT (16),
    .INSTRUCTION_WIDTH (32),
    .INSTRUCTION_COUNT (IC),
    .IMEM_LATENCY      (2)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .imem_addr_out   (imem_addr),
    .imem_data_in    (imem_data),
    .instr_out       (instr),
    .instr_valid_out (valid),
    .instr_ready_in  (ready),
    .busy_out        (busy),
    .done_out        (done),
    .fault_out       (fault)
  );

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [15:0] imm);
    return {4'h0, b, imm, a, op};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < IC; i++) mem[i] = '0;
  endtask

  task automatic wait_idle(input int budget, input int poke_at, output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = (k == poke_at);
      if (done) dones++;
      if (!busy) begin
        cycles = k;
        break;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (cycles == 0) begin
      n_bad++;
      $display("FAIL run_timeout: busy=%b after %0d cycles, required idle", busy, budget);
    end
  endtask

  task automatic run(input int budget, input int poke_at, output int cycles, output int dones);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(budget, poke_at, cycles, dones);
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 20 && !valid; k++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!valid) begin
      n_bad++;
      $display("FAIL %s: instr_valid_out=%b after %0d cycles, required 1", name, valid, k);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    n_cmp++; if ({done, fault} !== 2'b00) begin n_bad++; $display("FAIL rst_done_fault: got %b want 00", {done, fault}); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_cmp++; if (imem_addr !== 9'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", imem_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_rst: busy %b want 0", busy); end
  endtask

  // Three local opcodes at 4 cycles each: idle is seen 12 cycles after start.
  task automatic test_addi_program();
    int cyc, dn;
    clear_mem();
    mem[0] = enc(OP_ADDI, 4'd1, 4'd0, 16'd5);
    mem[1] = enc(OP_ADDI, 4'd2, 4'd1, 16'd7);
    mem[2] = enc(OP_END, 4'd0, 4'd0, 16'd0);
    run(100, 0, cyc, dn);
    n_cmp++; if (dut.u_regfile.regs_q[1] !== 16'd5)  begin n_bad++; $display("FAIL addi_r1: got %h want 0005", dut.u_regfile.regs_q[1]); end
    n_cmp++; if (dut.u_regfile.regs_q[2] !== 16'd12) begin n_bad++; $display("FAIL addi_r2: got %h want 000c", dut.u_regfile.regs_q[2]); end
    n_cmp++; if (dn !== 1)   begin n_bad++; $display("FAIL addi_done: got %0d pulses want 1", dn); end
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL addi_cycles: got %0d want 12", cyc); end
  endtask

  task automatic test_alu();
    int cyc, dn;
    clear_mem();
    mem[0] = enc(OP_ADDI, 4'd7, 4'd0, 16'hFFFF);
    mem[1] = enc(OP_ADDI, 4'd8, 4'd7, 16'h0001);
    mem[2] = enc(OP_ADDI, 4'd4, 4'd0, 16'h0F0F);
    mem[3] = enc(OP_ADDI, 4'd5, 4'd0, 16'h00FF);
    mem[4] = enc(OP_XOR,  4'd4, 4'd5, 16'h0000);
    mem[5] = enc(OP_NOP_ALT, 4'd4, 4'd4, 16'h0000);
    mem[6] = enc(OP_END,  4'd0, 4'd0, 16'h0000);
    run(200, 0, cyc, dn);
    n_cmp++; if (dut.u_regfile.regs_q[7] !== 16'hFFFF) begin n_bad++; $display("FAIL alu_r7: got %h want ffff", dut.u_regfile.regs_q[7]); end
    n_cmp++; if (dut.u_regfile.regs_q[8] !== 16'h0000) begin n_bad++; $display("FAIL addi_wrap: got %h want 0000", dut.u_regfile.regs_q[8]); end
    n_cmp++; if (dut.u_regfile.regs_q[4] !== 16'h0FF0) begin n_bad++; $display("FAIL xor_r4: got %h want 0ff0", dut.u_regfile.regs_q[4]); end
    n_cmp++; if (cyc !== 28) begin n_bad++; $display("FAIL alu_cycles: got %0d want 28", cyc); end
  endtask

  // r3=4, r1=1; body "ADDI r1,r1,1; BGE r3,r1; JUMP 0" repeats while r1<=4:
  // 4 passes leave r1=5, then pc falls through to END at index 3.
  task automatic test_loop();
    int cyc, dn;
    clear_mem();
    mem[0] = enc(OP_ADDI, 4'd3, 4'd0, 16'd4);
    mem[1] = enc(OP_ADDI, 4'd1, 4'd0, 16'd1);
    mem[2] = enc(OP_END,  4'd0, 4'd0, 16'd0);
    run(100, 0, cyc, dn);
    clear_mem();
    mem[0] = enc(OP_ADDI, 4'd1, 4'd1, 16'd1);
    mem[1] = enc(OP_BGE,  4'd3, 4'd1, 16'd0);
    mem[2] = enc(OP_JUMP, 4'd0, 4'd0, 16'd0);
    mem[3] = enc(OP_END,  4'd0, 4'd0, 16'd0);
    run(300, 0, cyc, dn);
    n_cmp++; if (dut.u_regfile.regs_q[1] !== 16'd5) begin n_bad++; $display("FAIL loop_r1: got %h want 0005", dut.u_regfile.regs_q[1]); end
    n_cmp++; if (cyc !== 52) begin n_bad++; $display("FAIL loop_cycles: got %0d want 52", cyc); end
    n_cmp++; if (dn !== 1)   begin n_bad++; $display("FAIL loop_done: got %0d want 1", dn); end
  endtask

  task automatic test_issue();
    int cyc, dn, vcnt, unstable;
    logic [31:0] exp_i;
    clear_mem();
    exp_i  = enc(4'h6, 4'd5, 4'd9, 16'hBEEF);
    mem[0] = exp_i;
    mem[1] = enc(OP_ADDI, 4'd6, 4'd0, 16'h0033);
    mem[2] = enc(OP_END,  4'd0, 4'd0, 16'h0000);
    ready  = 1'b0;
    hs_cnt = 0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_valid("issue_enter");
    vcnt = 0;
    unstable = 0;
    for (int c = 0; c < 5; c++) begin
      if (valid) vcnt++;
      if (instr !== exp_i) unstable++;
      @(posedge clk); #1;
    end
    ready = 1'b1;
    if (valid) vcnt++;
    if (instr !== exp_i) unstable++;
    @(posedge clk); #1;
    ready = 1'b0;
    n_cmp++; if (vcnt !== 6)     begin n_bad++; $display("FAIL issue_valid_cycles: got %0d want 6", vcnt); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL issue_stable: %0d cycles differed from %h, want 0", unstable, exp_i); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL issue_valid_fall: got %b want 0", valid); end
    n_cmp++; if (imem_addr !== 9'd1) begin n_bad++; $display("FAIL issue_pc: got %0d want 1", imem_addr); end
    wait_idle(100, 0, cyc, dn);
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL issue_handshakes: got %0d want 1", hs_cnt); end
    n_cmp++; if (dut.u_regfile.regs_q[6] !== 16'h0033) begin n_bad++; $display("FAIL issue_next: r6 %h want 0033", dut.u_regfile.regs_q[6]); end
  endtask

  // Ready already high: each issue lasts one cycle (5 cycles per issued op).
  task automatic test_back_to_back();
    int cyc, dn;
    clear_mem();
    mem[0] = enc(4'h7, 4'd1, 4'd2, 16'h1234);
    mem[1] = enc(4'hE, 4'd3, 4'd4, 16'h5678);
    mem[2] = enc(OP_END, 4'd0, 4'd0, 16'h0000);
    ready  = 1'b1;
    hs_cnt = 0;
    run(100, 0, cyc, dn);
    ready  = 1'b0;
    n_cmp++; if (hs_cnt !== 2) begin n_bad++; $display("FAIL b2b_handshakes: got %0d want 2", hs_cnt); end
    n_cmp++; if (cyc !== 14)   begin n_bad++; $display("FAIL b2b_cycles: got %0d want 14", cyc); end
  endtask

  task automatic test_fault();
    int cyc, dn;
    clear_mem();
    mem[0] = enc(OP_BGE,  4'd0, 4'd0, 16'd0);
    mem[1] = enc(OP_JUMP, 4'd0, 4'd0, 16'd600);
    mem[2] = enc(OP_END,  4'd0, 4'd0, 16'd0);
    run(100, 0, cyc, dn);
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_set: got %b want 1", fault); end
    n_cmp++; if (dn !== 0)       begin n_bad++; $display("FAIL fault_no_done: got %0d pulses want 0", dn); end
    n_cmp++; if (cyc !== 8)      begin n_bad++; $display("FAIL fault_cycles: got %0d want 8", cyc); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky: got %b want 1", fault); end
    clear_mem();
    mem[0] = enc(OP_END, 4'd0, 4'd0, 16'd0);
    run(100, 0, cyc, dn);
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got %b want 0", fault); end
    n_cmp++; if (dn !== 1)       begin n_bad++; $display("FAIL end_done: got %0d want 1", dn); end
  endtask

  task automatic test_reset_issue();
    int cyc, dn;
    clear_mem();
    mem[0] = enc(4'h6, 4'd1, 4'd1, 16'hAAAA);
    ready  = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_valid("rst_issue_enter");
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    n_cmp++; if ({dut.u_regfile.regs_q[1], dut.u_regfile.regs_q[3]} !== 32'h0)
      begin n_bad++; $display("FAIL rst_regs: r1 %h r3 %h want 0", dut.u_regfile.regs_q[1], dut.u_regfile.regs_q[3]); end
    ready  = 1'b1;
    hs_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({hs_cnt != 0, valid, busy} !== 3'b000)
      begin n_bad++; $display("FAIL rst_no_handshake: hs %0d valid %b busy %b want 0 0 0", hs_cnt, valid, busy); end
    ready  = 1'b0;
    clear_mem();
    mem[0] = enc(OP_ADDI, 4'd1, 4'd0, 16'd9);
    mem[1] = enc(OP_END,  4'd0, 4'd0, 16'd0);
    run(100, 0, cyc, dn);
    n_cmp++; if (dut.u_regfile.regs_q[1] !== 16'd9) begin n_bad++; $display("FAIL rst_restart_r1: got %h want 0009", dut.u_regfile.regs_q[1]); end
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL rst_restart_cycles: got %0d want 8", cyc); end
  endtask

  // All-NOP program runs to index 511 (512 x 4 cycles); a start pulse
  // mid-run must not restart it.
  task automatic test_no_end();
    int cyc, dn;
    clear_mem();
    run(3000, 100, cyc, dn);
    n_cmp++; if (cyc !== 2048) begin n_bad++; $display("FAIL no_end_cycles: got %0d want 2048", cyc); end
    n_cmp++; if (dn !== 1)     begin n_bad++; $display("FAIL no_end_done: got %0d want 1", dn); end
    n_cmp++; if (imem_addr !== 9'd0) begin n_bad++; $display("FAIL no_end_pc: got %0d want 0", imem_addr); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_addi_program();
    test_alu();
    test_loop();
    test_issue();
    test_back_to_back();
    test_fault();
    test_reset_issue();
    test_no_end();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
